// File: rtl/mips_mux_pkg.sv
// Shared types and defaults for the registered N:1 channel mux.
// Holds the output-stage state encoding plus the default channel width and count.
package mips_mux_pkg;

    localparam int MUX_DEF_WIDTH = 32;
    localparam int MUX_DEF_N     = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } mux_state_e;

    // Select width for a given channel count; never narrower than one bit.
    function automatic int mux_selw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_sel_n.sv
// Combinational N:1 channel select with an out-of-range indication.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller registers the result.
module mux_sel_n
    import mips_mux_pkg::*;
#(
    parameter int WIDTH = MUX_DEF_WIDTH,
    parameter int N     = MUX_DEF_N,
    parameter int SELW  = mux_selw(N)
) (
    input  logic [SELW-1:0]    i_sel,
    input  logic [N*WIDTH-1:0] i_din,
    output logic [WIDTH-1:0]   o_dout,
    output logic               o_oor
);

    // An index with no matching channel leaves o_dout zero and raises o_oor.
    always_comb begin
        o_dout = '0;
        o_oor  = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (int'(i_sel) == k) begin
                o_dout = i_din[k*WIDTH +: WIDTH];
                o_oor  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_reg_n.sv
// Registered N:1 mux with a one-entry valid/ready output stage; MUX_SEL_CHECK_EN adds err.
// Latency: one cycle from accept to out_valid; full throughput while out_ready is high.
// Backpressure: in_ready = EMPTY | out_ready, so a stalled output blocks new beats.
module mux_reg_n
    import mips_mux_pkg::*;
#(
    parameter int WIDTH = MUX_DEF_WIDTH,
    parameter int N     = MUX_DEF_N,
    parameter int SELW  = mux_selw(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SELW-1:0]    sel,
    input  logic [N*WIDTH-1:0] din,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   dout,
    output logic [SELW-1:0]    sel_q
`ifdef MUX_SEL_CHECK_EN
    ,
    output logic               err
`endif
);

    mux_state_e       r_state;
    mux_state_e       w_state_nxt;
    logic [WIDTH-1:0] r_dout;
    logic [SELW-1:0]  r_sel_q;
    logic [WIDTH-1:0] w_sel_dout;
    logic [WIDTH-1:0] w_dout_ld;
    logic             w_oor;
    logic             w_accept;
    logic             w_consume;
    logic             w_in_ready;

    mux_sel_n #(
        .WIDTH (WIDTH),
        .N     (N),
        .SELW  (SELW)
    ) u_sel (
        .i_sel  (sel),
        .i_din  (din),
        .o_dout (w_sel_dout),
        .o_oor  (w_oor)
    );

`ifdef MUX_SEL_CHECK_EN
    logic r_err;
    // Out-of-range beats carry zero data; err rides along with the beat.
    assign w_dout_ld = w_oor ? '0 : w_sel_dout;
    assign err       = r_err;
`else
    assign w_dout_ld = w_oor ? din[WIDTH-1:0] : w_sel_dout;
`endif

    assign w_accept  = in_valid & w_in_ready;
    assign w_consume = (r_state == FULL) & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b1;
        case (r_state)
            EMPTY: begin
                w_in_ready = 1'b1;
                if (w_accept) begin
                    w_state_nxt = FULL;
                end
            end
            FULL: begin
                w_in_ready = out_ready;
                // A simultaneous accept refills the stage, so only a bare consume empties it.
                if (w_consume && !w_accept) begin
                    w_state_nxt = EMPTY;
                end
            end
            default: begin
                w_state_nxt = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dout  <= '0;
            r_sel_q <= '0;
`ifdef MUX_SEL_CHECK_EN
            r_err   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_dout  <= w_dout_ld;
            r_sel_q <= sel;
`ifdef MUX_SEL_CHECK_EN
            r_err   <= w_oor;
`endif
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = (r_state == FULL);
    assign dout      = r_dout;
    assign sel_q     = r_sel_q;

endmodule

// File: doc/mux_reg_n.md
MUX_REG_N -- requirements
Module: mux_reg_n

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width per channel.
REQ-002 SHALL have parameter N, default 4, legal 2..16: input channel count.
REQ-003 SHALL have parameter SELW, default clog2(N): select width.
REQ-004 SHALL have port clk  input  1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1: upstream offers sel/din this cycle.
REQ-007 SHALL have port in_ready  output  1: block accepts when in_valid and in_ready are both high.
REQ-008 SHALL have port sel  input  SELW: channel index sampled on accept.
REQ-009 SHALL have port din  input  N*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-010 SHALL have port out_valid  output  1: dout holds a registered result.
REQ-011 SHALL have port out_ready  input  1: downstream consumes when out_valid and out_ready are both high.
REQ-012 SHALL have port dout  output  WIDTH: registered selected channel.
REQ-013 SHALL have port sel_q  output  SELW: sel value that produced dout.
REQ-014 SHALL have port err  output  1: registered out-of-range flag; exists only under MUX_SEL_CHECK_EN.

Function
REQ-015 SHALL implement a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 SHALL drive in_ready = (state==EMPTY) | out_ready, combinationally, with no dependence on in_valid.
REQ-017 On accept, SHALL load dout = din[sel], sel_q = sel, and enter FULL on the next edge; latency is 1 cycle.
REQ-018 EMPTY+accept SHALL go to FULL.
REQ-019 FULL+consume without accept SHALL go to EMPTY, and dout/sel_q SHALL hold their values.
REQ-020 FULL+consume+accept in the same cycle SHALL stay FULL, load the new data, and lose no beat.
REQ-021 FULL with out_ready=0 SHALL hold dout, sel_q and out_valid stable until consume.
REQ-022 SHALL treat sel >= N (non-power-of-2 N only) as out-of-range; behaviour is per REQ-027/028.
REQ-023 SHALL give full throughput: one beat per cycle while out_ready stays high.

Reset
REQ-024 Reset assertion SHALL immediately force state=EMPTY, out_valid=0, dout=0, sel_q=0 and err=0, independent of clk.
REQ-025 Reset asserted mid-transfer SHALL discard the held beat.
REQ-026 SHALL hold in_ready=1 during reset and for the first cycle after reset release.

Configuration
REQ-027 With MUX_SEL_CHECK_EN defined, an out-of-range accept SHALL load dout=0 and err=1; err SHALL travel with the beat and clear on the next load.
REQ-028 Without MUX_SEL_CHECK_EN, the err port SHALL be absent and an out-of-range sel SHALL select channel 0.

Structure
REQ-029 SHALL place the FSM state enum (EMPTY, FULL) and the default WIDTH/N constants in shared package mips_mux_pkg.
REQ-030 SHALL factor the combinational N:1 channel select into sub-module mux_sel_n (parameters WIDTH, N); all state SHALL live in mux_reg_n.

Verification
REQ-031 Reset release, N=4, WIDTH=32, din ch2=0xDEADBEEF, sel=2, in_valid pulse, out_ready=1 -> out_valid=1 next cycle, dout=0xDEADBEEF, sel_q=2.
REQ-032 Stream 8 beats sel=0,1,2,3,0,1,2,3 with out_ready=1 -> 8 consecutive out_valid cycles with matching data, in_ready never low.
REQ-033 FULL, out_ready=0 for 5 cycles, new din/sel offered -> in_ready=0 and dout unchanged; out_ready=1 -> held beat consumed and the new beat accepted in the same cycle.
REQ-034 N=3, sel=3 with MUX_SEL_CHECK_EN -> dout=0, err=1; the next legal beat gives err=0. Without the macro -> dout=din ch0.
REQ-035 Assert reset asynchronously between clock edges while FULL -> out_valid, dout and sel_q go to 0 before the next edge.
REQ-036 Random in_valid/out_ready, 10k cycles, scoreboard -> no lost, duplicated or reordered beats.
